// File: rtl/psg_bus_sequencer.sv
// Buffers host (register, value) writes and replays them on the AY-3-8913 BDIR/BC1/DA bus.
// Define PSG_SEQ_ADDR_CACHE_EN to skip LATCH when the address matches the last latched one.
module psg_bus_sequencer #(
    parameter int unsigned FIFO_DEPTH                 = 4,
    parameter int unsigned HOLD_CYCLES                = 1,
    parameter logic [3:0]  DA7_DA4_UPPER_ADDRESS_MASK = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] bus_data,
    output logic       bdir,
    output logic       bc1,
    output logic       busy,
    output logic       env_restart
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HoldReload = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FullCount  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLatch, StWrite, StGap} state_e;

    state_e        state_q, state_d, first_state;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [3:0]    cur_addr_q, cur_addr_d;
    logic [7:0]    cur_data_q, cur_data_d;

    logic [3:0]    fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full, empty;
    logic [3:0]    head_addr;
    logic [7:0]    head_data;

    logic          bdir_q, bdir_d, bc1_q, bc1_d, busy_q, busy_d;
    logic          env_q, env_d, ready_q, ready_d;
    logic [7:0]    bus_q, bus_d;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign push      = wr_valid & ~full;
    assign head_addr = fifo_addr_q[rptr_q];
    assign head_data = fifo_data_q[rptr_q];

`ifdef PSG_SEQ_ADDR_CACHE_EN
    logic [3:0] cache_addr_q;
    logic       cache_valid_q;

    assign first_state = (cache_valid_q && (head_addr == cache_addr_q)) ? StWrite : StLatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
        end else if (state_q == StLatch && cnt_q == '0) begin
            cache_valid_q <= 1'b1;
            cache_addr_q  <= cur_addr_q;
        end
    end
`else
    assign first_state = StLatch;
`endif

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle, StGap: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_d    = first_state;
                    cnt_d      = HoldReload;
                    cur_addr_d = head_addr;
                    cur_data_d = head_data;
                end else begin
                    state_d = StIdle;
                end
            end
            StLatch: begin
                if (cnt_q == '0) begin
                    state_d = StWrite;
                    cnt_d   = HoldReload;
                end else begin
                    cnt_d = cnt_q - HW'(1);
                end
            end
            StWrite: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = HoldReload;
                end else begin
                    cnt_d = cnt_q - HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values and registered.
    always_comb begin
        bdir_d  = 1'b0;
        bc1_d   = 1'b0;
        bus_d   = '0;
        env_d   = 1'b0;
        case (state_d)
            StLatch: begin
                bdir_d = 1'b1;
                bc1_d  = 1'b1;
                bus_d  = {DA7_DA4_UPPER_ADDRESS_MASK, cur_addr_d};
            end
            StWrite: begin
                bdir_d = 1'b1;
                bus_d  = cur_data_d;
                env_d  = (cnt_d == '0) && (cur_addr_d == 4'd13);
            end
            default: ;
        endcase
        busy_d  = (count_d != '0) || (state_d != StIdle);
        ready_d = (count_d != FullCount);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            bdir_q     <= 1'b0;
            bc1_q      <= 1'b0;
            bus_q      <= '0;
            env_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            bdir_q     <= bdir_d;
            bc1_q      <= bc1_d;
            bus_q      <= bus_d;
            env_q      <= env_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign bdir        = bdir_q;
    assign bc1         = bc1_q;
    assign bus_data    = bus_q;
    assign env_restart = env_q;
    assign busy        = busy_q;
    assign wr_ready    = ready_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Directed self-checking bench for psg_bus_sequencer (default parameters).
// Honours PSG_SEQ_ADDR_CACHE_EN for the repeated-address expectations.
module tb_psg_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] bus_data;
    logic       bdir;
    logic       bc1;
    logic       busy;
    logic       env_restart;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psg_bus_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bus_data   (bus_data),
        .bdir       (bdir),
        .bc1        (bc1),
        .busy       (busy),
        .env_restart(env_restart)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        step();
        total++;
        if ({bdir, bc1, bus_data} !== 10'h000) begin
            bad++;
            $display("FAIL reset_bus: got %h want 000", {bdir, bc1, bus_data});
        end
        total++;
        if ({env_restart, busy, wr_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_flags: got %b want 001", {env_restart, busy, wr_ready});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [9:0] exp_bus [4];
        logic       exp_busy [4];
        exp_bus  = '{10'h307, 10'h238, 10'h000, 10'h000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 8'h38;
        step();
        wr_valid = 1'b0;
        total++;
        if ({busy, bdir, bc1, bus_data} !== 11'h400) begin
            bad++;
            $display("FAIL single_accept: got %h want 400", {busy, bdir, bc1, bus_data});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({bdir, bc1, bus_data} !== exp_bus[i] || busy !== exp_busy[i] ||
                env_restart !== 1'b0) begin
                bad++;
                $display("FAIL single_cycle%0d: got bus=%h busy=%b env=%b want bus=%h busy=%b env=0",
                         i + 1, {bdir, bc1, bus_data}, busy, env_restart, exp_bus[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [3:0] a [4];
        logic [7:0] d [4];
        logic [9:0] exp;
        int         k;
        int         ph;
        a = '{4'd0, 4'd1, 4'd8, 4'd7};
        d = '{8'h11, 8'h02, 8'h0F, 8'h38};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c < 4) begin
                wr_valid = 1'b1;
                wr_addr  = a[c];
                wr_data  = d[c];
                total++;
                if (wr_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL burst_ready%0d: got %b want 1", c, wr_ready);
                end
            end else begin
                wr_valid = 1'b0;
            end
            step();
            if (c >= 1 && c <= 12) begin
                k  = (c - 1) / 3;
                ph = (c - 1) % 3;
                if (ph == 0)      exp = {2'b11, 4'h0, a[k]};
                else if (ph == 1) exp = {2'b10, d[k]};
                else              exp = 10'h000;
                total++;
                if ({bdir, bc1, bus_data} !== exp || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL burst_cycle%0d: got bus=%h busy=%b want bus=%h busy=1",
                             c, {bdir, bc1, bus_data}, busy, exp);
                end
            end else if (c == 13) begin
                total++;
                if ({busy, bdir, bc1, bus_data} !== 11'h000) begin
                    bad++;
                    $display("FAIL burst_idle: got %h want 000", {busy, bdir, bc1, bus_data});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_rdy;
        logic        prev_rdy;
        logic [7:0]  lat_q [$];
        logic [7:0]  dat_q [$];
        int          idx;
        int          n;
        logic        done;
        exp_rdy = 12'b0100_1001_1111;
        idx     = 0;
        done    = 1'b0;
        do_reset();
        for (int e = 0; e < 40 && !done; e++) begin
            prev_rdy = (e == 0) ? 1'b1 : ((e <= 12) ? exp_rdy[e-1] : 1'b1);
            wr_valid = (idx < 8);
            wr_addr  = 4'(idx + 1);
            wr_data  = 8'(8'hA0 + idx);
            step();
            if (wr_valid && prev_rdy) idx++;
            if (e < 12) begin
                total++;
                if (wr_ready !== exp_rdy[e]) begin
                    bad++;
                    $display("FAIL bp_ready_edge%0d: got %b want %b", e, wr_ready, exp_rdy[e]);
                end
            end
            if (bdir === 1'b1 && bc1 === 1'b1) lat_q.push_back(bus_data);
            if (bdir === 1'b1 && bc1 === 1'b0) dat_q.push_back(bus_data);
            if (e >= 12 && busy === 1'b0) done = 1'b1;
        end
        wr_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bp_drain: got busy=%b want 0 within 40 cycles", busy);
        end
        total++;
        if (lat_q.size() != 8 || dat_q.size() != 8) begin
            bad++;
            $display("FAIL bp_count: got latches=%0d writes=%0d want 8 and 8",
                     lat_q.size(), dat_q.size());
        end
        n = (lat_q.size() < dat_q.size()) ? lat_q.size() : dat_q.size();
        if (n > 8) n = 8;
        for (int i = 0; i < n; i++) begin
            total++;
            if (lat_q[i] !== 8'(i + 1) || dat_q[i] !== 8'(8'hA0 + i)) begin
                bad++;
                $display("FAIL bp_order%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, lat_q[i], dat_q[i], 8'(i + 1), 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_envelope();
        logic       exp_env [4];
        logic [9:0] exp_bus [4];
        int         pulses;
        exp_env = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_bus = '{10'h30D, 10'h20E, 10'h000, 10'h000};
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 4'd13;
        wr_data  = 8'h0E;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (env_restart !== exp_env[i] || {bdir, bc1, bus_data} !== exp_bus[i]) begin
                bad++;
                $display("FAIL env_r13_cycle%0d: got env=%b bus=%h want env=%b bus=%h",
                         i + 1, env_restart, {bdir, bc1, bus_data}, exp_env[i], exp_bus[i]);
            end
        end
        wr_valid = 1'b1;
        wr_addr  = 4'd12;
        wr_data  = 8'h0F;
        step();
        wr_valid = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (env_restart !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL env_r12: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_cache();
        logic [9:0] exp_bus [7];
        logic       exp_busy [7];
`ifdef PSG_SEQ_ADDR_CACHE_EN
        exp_bus  = '{10'h308, 10'h205, 10'h000, 10'h20A, 10'h000, 10'h000, 10'h000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_bus  = '{10'h308, 10'h205, 10'h000, 10'h308, 10'h20A, 10'h000, 10'h000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_valid = (i < 2);
            wr_addr  = 4'd8;
            wr_data  = (i == 0) ? 8'h05 : 8'h0A;
            step();
            if (i >= 1) begin
                total++;
                if ({bdir, bc1, bus_data} !== exp_bus[i-1] || busy !== exp_busy[i-1]) begin
                    bad++;
                    $display("FAIL cache_cycle%0d: got bus=%h busy=%b want bus=%h busy=%b",
                             i, {bdir, bc1, bus_data}, busy, exp_bus[i-1], exp_busy[i-1]);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_bus [2];
        exp_bus = '{10'h301, 10'h244};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(i + 1);
            wr_data  = 8'(8'h11 * (i + 1));
            step();
        end
        total++;
        if ({bdir, bc1, bus_data} !== 10'h211) begin
            bad++;
            $display("FAIL rst_mid_pre: got %h want 211", {bdir, bc1, bus_data});
        end
        wr_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({bdir, bc1, bus_data, env_restart, busy, wr_ready} !== 13'h0001) begin
            bad++;
            $display("FAIL rst_mid_abort: got %h want 0001",
                     {bdir, bc1, bus_data, env_restart, busy, wr_ready});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({bdir, bc1, bus_data, busy} !== 11'h000) begin
                bad++;
                $display("FAIL rst_mid_quiet%0d: got %h want 000", i, {bdir, bc1, bus_data, busy});
            end
        end
        // Same address as the aborted entry must still latch after reset.
        wr_valid = 1'b1;
        wr_addr  = 4'd1;
        wr_data  = 8'h44;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({bdir, bc1, bus_data} !== exp_bus[i]) begin
                bad++;
                $display("FAIL rst_mid_relatch%0d: got %h want %h",
                         i, {bdir, bc1, bus_data}, exp_bus[i]);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_envelope();
        test_cache();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
